ssd_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the Nexys-4 board. It replaces the single-digit static hex decode in the SINdoku top level. It scans N digits with frame-coherent input capture, per-digit enable, decimal-point and blink control, and an anti-ghosting blanking interval after every digit change. It sits between the game state machine (cursor position, cell values) and the board's An/Ca..Cg/Dp pins.

---
 rtl/ssd_pkg.sv | 23 ++
 rtl/ssd_hex_decode.sv | 32 +++
 rtl/ssd_scan_mux.sv | 141 ++++++++++++++
 tb/tb_ssd_scan_mux.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment constants for SINdoku display logic.
// Segment order is abcdefg, active-low (0 = segment lit).
package ssd_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b1100000;
    localparam logic [6:0] SEG_C   = 7'b0110001;
    localparam logic [6:0] SEG_D   = 7'b1000010;
    localparam logic [6:0] SEG_E   = 7'b0110000;
    localparam logic [6:0] SEG_F   = 7'b0111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low abcdefg segment pattern.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with frame-coherent capture,
// per-digit enable/dp/blink and an anti-ghosting blank after each digit change.
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 17,
    parameter int BLINK_DIV    = 26,
    parameter int BLANK_CYCLES = 4
)(
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [4*N_DIGITS-1:0]       digits_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic [N_DIGITS-1:0]         enable_in,
    input  logic [N_DIGITS-1:0]         blink_in,
    output logic [N_DIGITS-1:0]         An,
    output logic [7:0]                  Cathodes,
    output logic [$clog2(N_DIGITS)-1:0] scan_idx,
    output logic                        blink_phase,
    output logic                        frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] BLANK_LOAD = SCAN_DIV'(BLANK_CYCLES);

    logic [SCAN_DIV-1:0]     prescaler_reg, prescaler_next;
    logic [IDX_W-1:0]        scan_idx_reg, scan_idx_next;
    logic [SCAN_DIV-1:0]     blank_cnt_reg, blank_cnt_next;
    logic [BLINK_DIV-1:0]    blink_cnt_reg, blink_cnt_next;
    logic [4*N_DIGITS-1:0]   shadow_digits_reg, shadow_digits_next;
    logic [N_DIGITS-1:0]     shadow_dp_reg, shadow_dp_next;
    logic [N_DIGITS-1:0]     shadow_en_reg, shadow_en_next;
    logic [N_DIGITS-1:0]     shadow_blink_reg, shadow_blink_next;
    logic [N_DIGITS-1:0]     an_reg, an_next;
    logic [7:0]              cathodes_reg, cathodes_next;
    logic                    frame_start_reg, frame_start_next;

    logic                    tick;
    logic                    last_digit;
    logic                    blink_phase_next;
    logic                    digit_visible;
    logic [3:0]              sel_digit;
    logic [6:0]              sel_seg;
    logic [3:0]              digit_arr [N_DIGITS];

    assign tick       = (prescaler_reg == '1);
    assign last_digit = (scan_idx_reg == LAST_IDX);

    // Counters and shadow capture; the capture shares the wrap tick so digit 0
    // of the new frame already shows the freshly captured data.
    always_comb begin
        prescaler_next     = prescaler_reg + 1'b1;
        blink_cnt_next     = blink_cnt_reg + 1'b1;
        scan_idx_next      = scan_idx_reg;
        blank_cnt_next     = blank_cnt_reg;
        shadow_digits_next = shadow_digits_reg;
        shadow_dp_next     = shadow_dp_reg;
        shadow_en_next     = shadow_en_reg;
        shadow_blink_next  = shadow_blink_reg;
        frame_start_next   = 1'b0;
        if (tick) begin
            blank_cnt_next = BLANK_LOAD;
            if (last_digit) begin
                scan_idx_next      = '0;
                frame_start_next   = 1'b1;
                shadow_digits_next = digits_in;
                shadow_dp_next     = dp_in;
                shadow_en_next     = enable_in;
                shadow_blink_next  = blink_in;
            end else begin
                scan_idx_next = scan_idx_reg + 1'b1;
            end
        end else if (blank_cnt_reg != '0) begin
            blank_cnt_next = blank_cnt_reg - 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        assign digit_arr[gi] = shadow_digits_next[4*gi +: 4];
    end

    assign sel_digit = digit_arr[scan_idx_next];

    ssd_hex_decode u_decode (
        .hex (sel_digit),
        .seg (sel_seg)
    );

    // Outputs are computed from next-state values so the registered pins
    // line up with the registered scan index and blink phase.
    always_comb begin
        blink_phase_next = blink_cnt_next[BLINK_DIV-1];
        digit_visible    = shadow_en_next[scan_idx_next]
                           && !(blink_phase_next && shadow_blink_next[scan_idx_next]);
        an_next          = '1;
        cathodes_next    = 8'hFF;
        if (digit_visible) begin
            cathodes_next = {sel_seg, ~shadow_dp_next[scan_idx_next]};
            if (blank_cnt_next == '0) begin
                an_next[scan_idx_next] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prescaler_reg     <= '0;
            scan_idx_reg      <= '0;
            blank_cnt_reg     <= '0;
            blink_cnt_reg     <= '0;
            shadow_digits_reg <= '0;
            shadow_dp_reg     <= '0;
            shadow_en_reg     <= '0;
            shadow_blink_reg  <= '0;
            an_reg            <= '1;
            cathodes_reg      <= 8'hFF;
            frame_start_reg   <= 1'b0;
        end else begin
            prescaler_reg     <= prescaler_next;
            scan_idx_reg      <= scan_idx_next;
            blank_cnt_reg     <= blank_cnt_next;
            blink_cnt_reg     <= blink_cnt_next;
            shadow_digits_reg <= shadow_digits_next;
            shadow_dp_reg     <= shadow_dp_next;
            shadow_en_reg     <= shadow_en_next;
            shadow_blink_reg  <= shadow_blink_next;
            an_reg            <= an_next;
            cathodes_reg      <= cathodes_next;
            frame_start_reg   <= frame_start_next;
        end
    end

    assign An          = an_reg;
    assign Cathodes    = cathodes_reg;
    assign scan_idx    = scan_idx_reg;
    assign blink_phase = blink_cnt_reg[BLINK_DIV-1];
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed table-driven bench for ssd_scan_mux (4 digits, 4-clock digit slot,
// 1 blank clock, 32-clock blink period).
module tb_ssd_scan_mux;

    logic        Clk;
    logic        Reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  enable_in;
    logic [3:0]  blink_in;
    logic [3:0]  An;
    logic [7:0]  Cathodes;
    logic [1:0]  scan_idx;
    logic        blink_phase;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    ssd_scan_mux #(
        .N_DIGITS     (4),
        .SCAN_DIV     (2),
        .BLINK_DIV    (5),
        .BLANK_CYCLES (1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .enable_in   (enable_in),
        .blink_in    (blink_in),
        .An          (An),
        .Cathodes    (Cathodes),
        .scan_idx    (scan_idx),
        .blink_phase (blink_phase),
        .frame_start (frame_start)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  blink;
        logic [7:0]  n;
        logic [3:0]  an;
        logic [7:0]  cath;
        logic [1:0]  idx;
        logic        fs;
        logic        bp;
        logic        chk_cath;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [15:0] digits, input logic [3:0] dp,
                       input logic [3:0] en, input logic [3:0] blink, input logic [7:0] n,
                       input logic [3:0] an, input logic [7:0] cath, input logic [1:0] idx,
                       input logic fs, input logic bp, input logic chk_cath);
        vec_t v;
        v.rst = rst; v.digits = digits; v.dp = dp; v.en = en; v.blink = blink; v.n = n;
        v.an = an; v.cath = cath; v.idx = idx; v.fs = fs; v.bp = bp; v.chk_cath = chk_cath;
        vq.push_back(v);
    endtask

    // One clock, then check that no more than one anode is ever driven low.
    task automatic step_clk();
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (!$onehot0(~An)) begin
            errors++;
            $display("FAIL an_onehot got An=%b required at most one low bit", An);
        end
    endtask

    task automatic chk(input string name, input int vi, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL vec%0d %s got %h required %h", vi, name, got, want);
        end
    endtask

    initial begin
        Reset = 1'b1; digits_in = 16'h3210; dp_in = 4'h0; enable_in = 4'hF; blink_in = 4'h0;

        //   rst digits   dp    en    blink n   An     Cath   idx fs bp chk
        // reset, then dark until the first frame boundary
        add(1, 16'h3210, 4'h0, 4'hF, 4'h0,  3, 4'hF, 8'hFF, 0, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h0,  1, 4'hF, 8'hFF, 0, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h0,  3, 4'hF, 8'hFF, 1, 0, 0, 1);
        // first frame: blank clock then digit 0, digit 1
        add(0, 16'h3210, 4'h0, 4'hF, 4'h0, 12, 4'hF, 8'h00, 0, 1, 1, 0);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h0,  1, 4'hE, 8'h03, 0, 0, 1, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h0,  3, 4'hF, 8'h00, 1, 0, 1, 0);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h0,  1, 4'hD, 8'h9F, 1, 0, 1, 1);
        // mid-frame change to FFFF stays invisible until the next frame
        add(0, 16'hFFFF, 4'h0, 4'hF, 4'h0,  4, 4'hB, 8'h25, 2, 0, 1, 1);
        add(0, 16'hFFFF, 4'h0, 4'hF, 4'h0,  4, 4'h7, 8'h0D, 3, 0, 1, 1);
        add(0, 16'hFFFF, 4'h0, 4'hF, 4'h0,  3, 4'hF, 8'h00, 0, 1, 0, 0);
        add(0, 16'hFFFF, 4'h0, 4'hF, 4'h0,  1, 4'hE, 8'h71, 0, 0, 0, 1);
        // enable 1010 / dp 0010, effective from the following frame
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  4, 4'hD, 8'h71, 1, 0, 0, 1);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  4, 4'hB, 8'h71, 2, 0, 0, 1);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  4, 4'h7, 8'h71, 3, 0, 0, 1);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  3, 4'hF, 8'h00, 0, 1, 1, 0);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  1, 4'hF, 8'hFF, 0, 0, 1, 1);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  4, 4'hD, 8'h70, 1, 0, 1, 1);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  4, 4'hF, 8'hFF, 2, 0, 1, 1);
        add(0, 16'hFFFF, 4'h2, 4'hA, 4'h0,  4, 4'h7, 8'h71, 3, 0, 1, 1);
        // blink on digit 0: lit in phase 0, dark in phase 1
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  3, 4'hF, 8'h00, 0, 1, 0, 0);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  1, 4'hE, 8'h03, 0, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1, 15, 4'hF, 8'h00, 0, 1, 1, 0);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  1, 4'hF, 8'hFF, 0, 0, 1, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  4, 4'hD, 8'h9F, 1, 0, 1, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1, 12, 4'hE, 8'h03, 0, 0, 0, 1);
        // reset while digit 2 is lit, then shadow must be empty again
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  8, 4'hB, 8'h25, 2, 0, 0, 1);
        add(1, 16'h3210, 4'h0, 4'hF, 4'h1,  1, 4'hF, 8'hFF, 0, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  1, 4'hF, 8'hFF, 0, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  3, 4'hF, 8'hFF, 1, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  1, 4'hF, 8'hFF, 1, 0, 0, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1, 11, 4'hF, 8'h00, 0, 1, 1, 0);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  1, 4'hF, 8'hFF, 0, 0, 1, 1);
        add(0, 16'h3210, 4'h0, 4'hF, 4'h1,  4, 4'hD, 8'h9F, 1, 0, 1, 1);

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            Reset     = v.rst;
            digits_in = v.digits;
            dp_in     = v.dp;
            enable_in = v.en;
            blink_in  = v.blink;
            for (int c = 0; c < int'(v.n); c++) step_clk();
            chk("An", i, {4'h0, An}, {4'h0, v.an});
            chk("scan_idx", i, {6'h0, scan_idx}, {6'h0, v.idx});
            chk("frame_start", i, {7'h0, frame_start}, {7'h0, v.fs});
            chk("blink_phase", i, {7'h0, blink_phase}, {7'h0, v.bp});
            if (v.chk_cath) chk("Cathodes", i, Cathodes, v.cath);
            $display("vec%0d rst=%0b An=%b Cath=%h idx=%0d fs=%0b bp=%0b",
                     i, v.rst, An, Cathodes, scan_idx, frame_start, blink_phase);
        end

        // frame_start must be a single-clock pulse
        Reset = 1'b0;
        for (int c = 0; c < 40 && frame_start !== 1'b1; c++) step_clk();
        chk("fs_seen", 99, {7'h0, frame_start}, 8'h01);
        step_clk();
        chk("fs_width", 99, {7'h0, frame_start}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
